// File: rtl/uart_tx_queue.sv
// Transmit queue ahead of the UART: circular byte FIFO on SysClk plus a pacing FSM
// that hands one character at a time to the UART using a synchronised Tx_Busy handshake.
module uart_tx_queue #(
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned FIFO_WIDTH    = 4,
    parameter int unsigned START_TIMEOUT = 4096
) (
    input  logic                  SysClk,
    input  logic                  Rst,
    input  logic                  Push_Data,
    input  logic [DATA_BITS-1:0]  Host_Data,
    input  logic                  Clr_Flags,
    input  logic                  Tx_Busy,
    input  logic                  CTS,
    input  logic                  BIST_Busy,
    output logic [DATA_BITS-1:0]  Tx_Data,
    output logic                  Transmit_Start,
    output logic                  TxQ_Empty,
    output logic                  TxQ_Full,
    output logic [FIFO_WIDTH:0]   TxQ_Count,
    output logic                  TxQ_Overflow,
    output logic                  Tx_Timeout
);

    localparam int unsigned DEPTH = 1 << FIFO_WIDTH;
    localparam int unsigned PW    = FIFO_WIDTH + 1;
    localparam int unsigned TW    = $clog2(START_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]          count_q, count_d;
    logic                   empty_q, empty_d;
    logic                   full_q, full_d;
    logic [DATA_BITS-1:0]   tx_data_q, tx_data_d;
    logic                   start_q, start_d;
    logic                   ovf_q, ovf_d;
    logic                   tmo_q, tmo_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   cts_meta_q, cts_s_q;
    logic                   busy_meta_q, busy_s_q;
    logic [DATA_BITS-1:0]   mem_q [DEPTH];

    logic                   pop;
    logic                   push_ok;
    logic                   drop;
    logic                   tmo_set;

    // Queue pointer bookkeeping; a pop in LOAD frees a slot for a same-cycle push
    always_comb begin
        pop      = (state_q == S_LOAD);
        push_ok  = Push_Data && (!full_q || pop);
        drop     = Push_Data && !push_ok;
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = wr_ptr_d - rd_ptr_d;
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[FIFO_WIDTH] != rd_ptr_d[FIFO_WIDTH]) &&
                   (wr_ptr_d[FIFO_WIDTH-1:0] == rd_ptr_d[FIFO_WIDTH-1:0]);
    end

    // Pacing FSM: flow control gates only the IDLE->LOAD decision
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        timer_d   = timer_q;
        tmo_set   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty_q && cts_s_q && !BIST_Busy) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                tx_data_d = mem_q[rd_ptr_q[FIFO_WIDTH-1:0]];
                timer_d   = '0;
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                timer_d = timer_q + TW'(1);
                if (busy_s_q) begin
                    state_d = S_WAIT_DONE;
                end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    tmo_set = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!busy_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        start_d = (state_d == S_ISSUE);
        ovf_d   = drop    || (ovf_q && !Clr_Flags);
        tmo_d   = tmo_set || (tmo_q && !Clr_Flags);
    end

    always_ff @(posedge SysClk or posedge Rst) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            tx_data_q   <= '0;
            start_q     <= 1'b0;
            ovf_q       <= 1'b0;
            tmo_q       <= 1'b0;
            timer_q     <= '0;
            cts_meta_q  <= 1'b0;
            cts_s_q     <= 1'b0;
            busy_meta_q <= 1'b0;
            busy_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            tx_data_q   <= tx_data_d;
            start_q     <= start_d;
            ovf_q       <= ovf_d;
            tmo_q       <= tmo_d;
            timer_q     <= timer_d;
            cts_meta_q  <= CTS;
            cts_s_q     <= cts_meta_q;
            busy_meta_q <= Tx_Busy;
            busy_s_q    <= busy_meta_q;
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers
    always_ff @(posedge SysClk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[FIFO_WIDTH-1:0]] <= Host_Data;
        end
    end

    assign Tx_Data        = tx_data_q;
    assign Transmit_Start = start_q;
    assign TxQ_Empty      = empty_q;
    assign TxQ_Full       = full_q;
    assign TxQ_Count      = count_q;
    assign TxQ_Overflow   = ovf_q;
    assign Tx_Timeout     = tmo_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue with a baud-clock UART model that acknowledges
// starts by holding Tx_Busy for 10 baud clocks and records every captured character.
module tb_uart_tx_queue;

    localparam int unsigned DB = 8;
    localparam int unsigned FW = 4;
    localparam int unsigned TO = 64;

    logic          SysClk = 1'b0;
    logic          bclk   = 1'b0;
    logic          Rst = 1'b1;
    logic          Push_Data = 1'b0;
    logic [DB-1:0] Host_Data = '0;
    logic          Clr_Flags = 1'b0;
    logic          Tx_Busy = 1'b0;
    logic          CTS = 1'b0;
    logic          BIST_Busy = 1'b0;
    logic [DB-1:0] Tx_Data;
    logic          Transmit_Start;
    logic          TxQ_Empty;
    logic          TxQ_Full;
    logic [FW:0]   TxQ_Count;
    logic          TxQ_Overflow;
    logic          Tx_Timeout;

    logic          uart_en = 1'b0;
    int            bcnt = 0;
    logic [DB-1:0] exp_q[$];
    logic [DB-1:0] got_q[$];
    int            total = 0;
    int            bad = 0;

    uart_tx_queue #(.DATA_BITS(DB), .FIFO_WIDTH(FW), .START_TIMEOUT(TO)) dut (
        .SysClk(SysClk), .Rst(Rst), .Push_Data(Push_Data), .Host_Data(Host_Data),
        .Clr_Flags(Clr_Flags), .Tx_Busy(Tx_Busy), .CTS(CTS), .BIST_Busy(BIST_Busy),
        .Tx_Data(Tx_Data), .Transmit_Start(Transmit_Start), .TxQ_Empty(TxQ_Empty),
        .TxQ_Full(TxQ_Full), .TxQ_Count(TxQ_Count), .TxQ_Overflow(TxQ_Overflow),
        .Tx_Timeout(Tx_Timeout)
    );

    always #5 SysClk = ~SysClk;
    always #18.5 bclk = ~bclk;

    // UART model on the baud clock
    always @(posedge bclk) begin
        if (!uart_en) begin
            Tx_Busy <= 1'b0;
            bcnt    <= 0;
        end else if (Tx_Busy) begin
            if (bcnt == 9) Tx_Busy <= 1'b0;
            bcnt <= bcnt + 1;
        end else if (Transmit_Start) begin
            Tx_Busy <= 1'b1;
            bcnt    <= 0;
            got_q.push_back(Tx_Data);
        end
    end

    task automatic wait_got(input int n, output bit ok);
        int k;
        k = 0;
        while (got_q.size() < n && k < 80 * n + 200) begin
            @(posedge SysClk);
            k++;
        end
        #1;
        ok = (got_q.size() >= n);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!(TxQ_Empty && !Transmit_Start && !Tx_Busy) && k < 3000) begin
            @(posedge SysClk);
            #1;
            k++;
        end
        repeat (6) @(posedge SysClk);
        #1;
        if (k >= 3000) begin
            total++;
            bad++;
            $display("FAIL idle_wait: got busy after %0d cycles want idle", k);
        end
    endtask

    task automatic push_byte(input logic [DB-1:0] b, input bit expect_tx);
        @(negedge SysClk);
        Push_Data = 1'b1;
        Host_Data = b;
        if (expect_tx) exp_q.push_back(b);
        @(posedge SysClk);
        #1;
        Push_Data = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (Tx_Data !== 8'h00) begin bad++; $display("FAIL rst_tx_data: got %0h want 0", Tx_Data); end
        total++; if (Transmit_Start !== 1'b0) begin bad++; $display("FAIL rst_start: got %0b want 0", Transmit_Start); end
        total++; if (TxQ_Empty !== 1'b1) begin bad++; $display("FAIL rst_empty: got %0b want 1", TxQ_Empty); end
        total++; if (TxQ_Full !== 1'b0) begin bad++; $display("FAIL rst_full: got %0b want 0", TxQ_Full); end
        total++; if (TxQ_Count !== 5'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", TxQ_Count); end
        total++; if (TxQ_Overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %0b want 0", TxQ_Overflow); end
        total++; if (Tx_Timeout !== 1'b0) begin bad++; $display("FAIL rst_tmo: got %0b want 0", Tx_Timeout); end
    endtask

    task automatic test_basic();
        bit ok;
        logic [DB-1:0] g, e;
        CTS = 1'b1;
        uart_en = 1'b1;
        repeat (5) @(posedge SysClk);
        @(negedge SysClk);
        Push_Data = 1'b1;
        Host_Data = 8'h41;
        exp_q.push_back(8'h41);
        @(posedge SysClk);
        #1;
        total++; if (TxQ_Empty !== 1'b0) begin bad++; $display("FAIL basic_empty_after_push: got %0b want 0", TxQ_Empty); end
        Host_Data = 8'h42;
        exp_q.push_back(8'h42);
        @(posedge SysClk);
        #1;
        total++; if (Transmit_Start !== 1'b0) begin bad++; $display("FAIL basic_start_early: got %0b want 0", Transmit_Start); end
        Host_Data = 8'h43;
        exp_q.push_back(8'h43);
        @(posedge SysClk);
        #1;
        Push_Data = 1'b0;
        total++; if (Transmit_Start !== 1'b1) begin bad++; $display("FAIL basic_start_latency: got %0b want 1", Transmit_Start); end
        total++; if (Tx_Data !== 8'h41) begin bad++; $display("FAIL basic_first_data: got %0h want 41", Tx_Data); end
        wait_got(3, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_got_count: got %0d want 3", got_q.size()); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total++; if (g !== e) begin bad++; $display("FAIL basic_data: got %0h want %0h", g, e); end
        end
        wait_idle();
        total++; if (TxQ_Empty !== 1'b1) begin bad++; $display("FAIL basic_empty_end: got %0b want 1", TxQ_Empty); end
    endtask

    task automatic test_overflow_and_full_pushpop();
        bit ok;
        logic [DB-1:0] g, e;
        wait_idle();
        CTS = 1'b0;
        repeat (4) @(posedge SysClk);
        for (int i = 0; i < 17; i++) begin
            @(negedge SysClk);
            Push_Data = 1'b1;
            Host_Data = (i < 16) ? DB'(i + 1) : 8'hEE;
            if (i < 16) exp_q.push_back(DB'(i + 1));
            @(posedge SysClk);
            #1;
            if (i == 15) begin
                total++; if (TxQ_Full !== 1'b1) begin bad++; $display("FAIL ovf_full_at_16: got %0b want 1", TxQ_Full); end
                total++; if (TxQ_Overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %0b want 0", TxQ_Overflow); end
            end
            if (i == 16) begin
                total++; if (TxQ_Overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %0b want 1", TxQ_Overflow); end
                total++; if (TxQ_Count !== 5'd16) begin bad++; $display("FAIL ovf_count: got %0d want 16", TxQ_Count); end
            end
        end
        Push_Data = 1'b0;
        @(negedge SysClk);
        Clr_Flags = 1'b1;
        @(posedge SysClk);
        #1;
        Clr_Flags = 1'b0;
        total++; if (TxQ_Overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %0b want 0", TxQ_Overflow); end
        // CTS rises; sync takes two edges, LOAD entered on the third
        @(negedge SysClk);
        CTS = 1'b1;
        repeat (3) @(posedge SysClk);
        #1;
        Push_Data = 1'b1;
        Host_Data = 8'h99;
        exp_q.push_back(8'h99);
        @(posedge SysClk);
        #1;
        Push_Data = 1'b0;
        total++; if (Transmit_Start !== 1'b1) begin bad++; $display("FAIL pushpop_issue: got %0b want 1", Transmit_Start); end
        total++; if (TxQ_Count !== 5'd16) begin bad++; $display("FAIL pushpop_count: got %0d want 16", TxQ_Count); end
        total++; if (TxQ_Full !== 1'b1) begin bad++; $display("FAIL pushpop_full: got %0b want 1", TxQ_Full); end
        total++; if (TxQ_Overflow !== 1'b0) begin bad++; $display("FAIL pushpop_ovf: got %0b want 0", TxQ_Overflow); end
        wait_got(17, ok);
        total++; if (!ok) begin bad++; $display("FAIL ovf_got_count: got %0d want 17", got_q.size()); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total++; if (g !== e) begin bad++; $display("FAIL ovf_data: got %0h want %0h", g, e); end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL ovf_leftover: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        int n;
        bit ok;
        logic [DB-1:0] g, e;
        wait_idle();
        uart_en = 1'b0;
        repeat (8) @(posedge SysClk);
        push_byte(8'h55, 1'b0);
        push_byte(8'h66, 1'b1);
        n = 0;
        while (!Transmit_Start && n < 20) begin @(posedge SysClk); #1; n++; end
        n = 0;
        while (Transmit_Start && n < TO + 10) begin n++; @(posedge SysClk); #1; end
        total++; if (n != TO) begin bad++; $display("FAIL tmo_start_width: got %0d want %0d", n, TO); end
        total++; if (Tx_Timeout !== 1'b1) begin bad++; $display("FAIL tmo_flag: got %0b want 1", Tx_Timeout); end
        uart_en = 1'b1;
        n = 0;
        while (!Transmit_Start && n < 20) begin @(posedge SysClk); #1; n++; end
        total++; if (Tx_Data !== 8'h66) begin bad++; $display("FAIL tmo_next_data: got %0h want 66", Tx_Data); end
        wait_got(1, ok);
        total++; if (!ok) begin bad++; $display("FAIL tmo_got_count: got %0d want 1", got_q.size()); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total++; if (g !== e) begin bad++; $display("FAIL tmo_data: got %0h want %0h", g, e); end
        end
        total++; if (Tx_Timeout !== 1'b1) begin bad++; $display("FAIL tmo_sticky: got %0b want 1", Tx_Timeout); end
        @(negedge SysClk);
        Clr_Flags = 1'b1;
        @(posedge SysClk);
        #1;
        Clr_Flags = 1'b0;
        total++; if (Tx_Timeout !== 1'b0) begin bad++; $display("FAIL tmo_clear: got %0b want 0", Tx_Timeout); end
    endtask

    task automatic test_bist();
        bit ok;
        bit seen;
        logic [DB-1:0] g, e;
        wait_idle();
        BIST_Busy = 1'b1;
        push_byte(8'hA1, 1'b1);
        push_byte(8'hA2, 1'b1);
        push_byte(8'hA3, 1'b1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge SysClk);
            #1;
            if (Transmit_Start === 1'b1) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL bist_no_start: got %0b want 0", seen); end
        total++; if (TxQ_Count !== 5'd3) begin bad++; $display("FAIL bist_count: got %0d want 3", TxQ_Count); end
        BIST_Busy = 1'b0;
        wait_got(3, ok);
        total++; if (!ok) begin bad++; $display("FAIL bist_got_count: got %0d want 3", got_q.size()); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total++; if (g !== e) begin bad++; $display("FAIL bist_data: got %0h want %0h", g, e); end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int k;
        logic [DB-1:0] g, e;
        wait_idle();
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 30)) @(posedge SysClk);
            k = 0;
            #1;
            while (TxQ_Full && k < 2000) begin @(posedge SysClk); #1; k++; end
            push_byte(DB'($urandom), 1'b1);
        end
        wait_got(40, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_got_count: got %0d want 40", got_q.size()); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total++; if (g !== e) begin bad++; $display("FAIL wrap_data: got %0h want %0h", g, e); end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wrap_leftover: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int n;
        wait_idle();
        push_byte(8'h11, 1'b1);
        push_byte(8'h22, 1'b1);
        push_byte(8'h33, 1'b1);
        n = 0;
        while (!Transmit_Start && n < 20) begin @(posedge SysClk); #1; n++; end
        n = 0;
        while (Transmit_Start && n < TO + 10) begin @(posedge SysClk); #1; n++; end
        // now in WAIT_DONE with two bytes still queued
        @(negedge SysClk);
        #2;
        Rst = 1'b1;
        #1;
        total++; if (Transmit_Start !== 1'b0) begin bad++; $display("FAIL rmid_start: got %0b want 0", Transmit_Start); end
        total++; if (Tx_Data !== 8'h00) begin bad++; $display("FAIL rmid_tx_data: got %0h want 0", Tx_Data); end
        total++; if (TxQ_Empty !== 1'b1) begin bad++; $display("FAIL rmid_empty: got %0b want 1", TxQ_Empty); end
        total++; if (TxQ_Count !== 5'd0) begin bad++; $display("FAIL rmid_count: got %0d want 0", TxQ_Count); end
        total++; if (TxQ_Full !== 1'b0) begin bad++; $display("FAIL rmid_full: got %0b want 0", TxQ_Full); end
        total++; if (TxQ_Overflow !== 1'b0 || Tx_Timeout !== 1'b0) begin bad++; $display("FAIL rmid_flags: got %0b%0b want 00", TxQ_Overflow, Tx_Timeout); end
        @(negedge SysClk);
        Rst = 1'b0;
        exp_q.delete();
        got_q.delete();
        repeat (100) @(posedge SysClk);
        #1;
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL rmid_no_tx: got %0d want 0", got_q.size()); end
    endtask

    initial begin
        repeat (3) @(posedge SysClk);
        @(negedge SysClk);
        Rst = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_overflow_and_full_pushpop();
        test_timeout();
        test_bist();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
